// File: rtl/trap_sequencer.sv
// trap_sequencer
//   Machine-mode trap controller. Takes synchronous exception requests
//   (ECALL, EBREAK, illegal instruction, instruction fetch fault) and MRET,
//   owns mtvec/mepc/mcause/mtval, and steps every trap through
//   DRAIN -> COMMIT (flush) -> REDIRECT before returning to IDLE.
//
// Ports
//   clk, rst              core clock; asynchronous active-low reset
//   dec_*                 decode-stage instruction, PC and exception/MRET flags
//   if_fault, if_misaligned, if_pc
//                         fetch fault on the next instruction and its address
//   pipe_idle             no older instruction remains in EX/LSU/WB
//   busy                  sequence in progress (stalls decode and fetch)
//   flush                 one-cycle pulse invalidating fetch and decode
//   redirect_valid/_pc    new fetch PC offered to ifetch
//   redirect_ready        ifetch accepts the redirect
//   csr_addr/wen/wdata    CSR access from the decode CSR instruction
//   csr_hit, csr_rdata    combinational hit flag and read data

module trap_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_valid,
  input  logic            dec_ecall,
  input  logic            dec_ebreak,
  input  logic            dec_illegal,
  input  logic            dec_mret,
  input  logic [XLEN-1:0] dec_pc,
  input  logic [31:0]     dec_instr,
  input  logic            if_fault,
  input  logic            if_misaligned,
  input  logic [XLEN-1:0] if_pc,
  input  logic            pipe_idle,
  output logic            busy,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  input  logic [11:0]     csr_addr,
  input  logic            csr_wen,
  input  logic [XLEN-1:0] csr_wdata,
  output logic            csr_hit,
  output logic [XLEN-1:0] csr_rdata
);

  localparam logic [11:0] ADDR_MTVEC  = 12'h305;
  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;
  localparam logic [11:0] ADDR_MTVAL  = 12'h343;

  localparam logic [XLEN-1:0] CAUSE_FETCH_MISALIGNED = XLEN'(0);
  localparam logic [XLEN-1:0] CAUSE_FETCH_ACCESS     = XLEN'(1);
  localparam logic [XLEN-1:0] CAUSE_ILLEGAL          = XLEN'(2);
  localparam logic [XLEN-1:0] CAUSE_EBREAK           = XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_ECALL            = XLEN'(11);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  // Only direct-mode vectors and word-aligned PCs are supported.
  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] v);
    return {v[XLEN-1:2], 2'b00};
  endfunction

  // Only synchronous exceptions exist here, so the interrupt bit stays clear.
  function automatic logic [XLEN-1:0] clr_irq_bit(input logic [XLEN-1:0] v);
    return {1'b0, v[XLEN-2:0]};
  endfunction

  state_t          state;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;

  // Request captured in IDLE and carried through the sequence
  logic            lat_mret;
  logic [XLEN-1:0] lat_cause;
  logic [XLEN-1:0] lat_pc;
  logic [XLEN-1:0] lat_tval;

  // Request decode
  logic            dec_req;
  logic            any_req;
  logic            req_mret;
  logic [XLEN-1:0] req_cause;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] req_tval;

  always_comb begin
    req_mret  = 1'b0;
    req_cause = '0;
    req_pc    = dec_pc;
    req_tval  = '0;
    dec_req   = dec_valid & (dec_ecall | dec_ebreak | dec_illegal | dec_mret);
    // The decode instruction is older than the next fetch, so it wins; a
    // concurrent fetch fault is dropped and refetched after the flush.
    if (dec_req) begin
      if (dec_illegal) begin
        req_cause = CAUSE_ILLEGAL;
        req_tval  = XLEN'(dec_instr);
      end else if (dec_ecall) begin
        req_cause = CAUSE_ECALL;
      end else if (dec_ebreak) begin
        req_cause = CAUSE_EBREAK;
      end else begin
        req_mret  = 1'b1;
      end
    end else if (if_fault) begin
      req_pc    = if_pc;
      req_tval  = if_pc;
      req_cause = if_misaligned ? CAUSE_FETCH_MISALIGNED : CAUSE_FETCH_ACCESS;
    end
  end

  assign any_req = dec_req | if_fault;

  // CSR read port
  always_comb begin
    csr_hit   = 1'b1;
    csr_rdata = '0;
    unique case (csr_addr)
      ADDR_MTVEC:  csr_rdata = mtvec;
      ADDR_MEPC:   csr_rdata = mepc;
      ADDR_MCAUSE: csr_rdata = mcause;
      ADDR_MTVAL:  csr_rdata = mtval;
      default:     csr_hit   = 1'b0;
    endcase
  end

  // Request latch; data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && any_req) begin
      lat_mret  <= req_mret;
      lat_cause <= req_cause;
      lat_pc    <= req_pc;
      lat_tval  <= req_tval;
    end
  end

  // Sequencer with registered outputs and the trap CSRs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mtvec          <= '0;
      mepc           <= '0;
      mcause         <= '0;
      mtval          <= '0;
    end else begin
      flush <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            // A CSR write in the trapping cycle belongs to an instruction
            // that must not retire, so it is dropped here.
            state <= DRAIN;
            busy  <= 1'b1;
          end else if (csr_wen && csr_hit) begin
            unique case (csr_addr)
              ADDR_MTVEC:  mtvec  <= align4(csr_wdata);
              ADDR_MEPC:   mepc   <= align4(csr_wdata);
              ADDR_MCAUSE: mcause <= clr_irq_bit(csr_wdata);
              default:     mtval  <= csr_wdata;
            endcase
          end
        end
        DRAIN: begin
          if (pipe_idle) begin
            state <= COMMIT;
            flush <= 1'b1;
          end
        end
        COMMIT: begin
          if (!lat_mret) begin
            mepc   <= align4(lat_pc);
            mcause <= lat_cause;
            mtval  <= lat_tval;
          end
          // COMMIT never writes mtvec, and MRET never writes mepc, so the
          // pre-commit values are already the post-commit targets.
          redirect_pc    <= lat_mret ? mepc : mtvec;
          redirect_valid <= 1'b1;
          state          <= REDIRECT;
        end
        REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer
//   Scoreboard bench for trap_sequencer. The stimulus process computes each
//   expected trap outcome from the architectural rules and queues it; the
//   monitor process compares whenever the DUT presents busy/flush/redirect
//   or a CSR read is strobed.

module tb_trap_sequencer;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            dec_valid, dec_ecall, dec_ebreak, dec_illegal, dec_mret;
  logic [XLEN-1:0] dec_pc;
  logic [31:0]     dec_instr;
  logic            if_fault, if_misaligned;
  logic [XLEN-1:0] if_pc;
  logic            pipe_idle;
  logic            busy, flush, redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;
  logic [11:0]     csr_addr;
  logic            csr_wen;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_hit;
  logic [XLEN-1:0] csr_rdata;
  logic            rd_chk;

  trap_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ecall(dec_ecall), .dec_ebreak(dec_ebreak),
    .dec_illegal(dec_illegal), .dec_mret(dec_mret),
    .dec_pc(dec_pc), .dec_instr(dec_instr),
    .if_fault(if_fault), .if_misaligned(if_misaligned), .if_pc(if_pc),
    .pipe_idle(pipe_idle),
    .busy(busy), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready),
    .csr_addr(csr_addr), .csr_wen(csr_wen), .csr_wdata(csr_wdata),
    .csr_hit(csr_hit), .csr_rdata(csr_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit              is_read;
    logic            hit;
    logic [XLEN-1:0] rdata;   // csr_rdata expected (at redirect accept for traps)
    logic [XLEN-1:0] rpc;
    int              req_cyc;
    int              extra;   // DRAIN cycles beyond the minimum one
    int              hold;    // cycles redirect_ready is held low
  } exp_t;

  exp_t q[$];

  // Reference CSR state: 0 mtvec, 1 mepc, 2 mcause, 3 mtval
  logic [XLEN-1:0] m_csr [4];

  function automatic int csr_idx(input logic [11:0] a);
    case (a)
      12'h305: return 0;
      12'h341: return 1;
      12'h342: return 2;
      12'h343: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [11:0] rand_hit_addr();
    case ($urandom_range(0, 3))
      0:       return 12'h305;
      1:       return 12'h341;
      2:       return 12'h342;
      default: return 12'h343;
    endcase
  endfunction

  function automatic logic [11:0] rand_addr();
    if ($urandom_range(0, 5) == 0) return 12'h300;
    return rand_hit_addr();
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_csr[i] = '0;
  endtask

  task automatic clear_req();
    dec_valid = 0; dec_ecall = 0; dec_ebreak = 0; dec_illegal = 0; dec_mret = 0;
    if_fault = 0; if_misaligned = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    q.delete();
    model_reset();
    clear_req();
    csr_wen = 0; redirect_ready = 0; pipe_idle = 1;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [XLEN-1:0] d);
    int ix;
    ix = csr_idx(a);
    if (ix == 0 || ix == 1) m_csr[ix] = d & ~32'h3;
    else if (ix == 2)       m_csr[ix] = d & 32'h7FFF_FFFF;
    else if (ix == 3)       m_csr[ix] = d;
    // Decode may hold a non-trapping instruction during the write
    dec_valid = $urandom_range(0, 1);
    csr_addr = a; csr_wdata = d; csr_wen = 1;
    step();
    csr_wen = 0; dec_valid = 0;
  endtask

  task automatic csr_read(input logic [11:0] a);
    exp_t e;
    int ix;
    ix = csr_idx(a);
    e.is_read = 1;
    e.hit     = (ix >= 0);
    e.rdata   = (ix >= 0) ? m_csr[ix] : '0;
    e.rpc = '0; e.req_cyc = 0; e.extra = 0; e.hold = 0;
    q.push_back(e);
    csr_addr = a; rd_chk = 1;
    step();
    rd_chk = 0;
  endtask

  // kind: 0 ECALL, 1 EBREAK, 2 illegal, 3 MRET, 4 fetch misaligned, 5 fetch access
  task automatic do_seq(input int kind, input logic [XLEN-1:0] pc,
                        input logic [31:0] instr, input logic [XLEN-1:0] ifpc,
                        input int k, input int h, input bit wen,
                        input logic [11:0] waddr, input logic [XLEN-1:0] wdata,
                        input bit extra_fault, input bit busy_wr,
                        input logic [11:0] raddr);
    exp_t e;
    int n;
    if (kind != 3) begin
      logic [XLEN-1:0] tpc;
      tpc = (kind >= 4) ? ifpc : pc;
      m_csr[1] = tpc & ~32'h3;
      m_csr[2] = (kind == 0) ? 11 : (kind == 1) ? 3 : (kind == 2) ? 2 : (kind == 4) ? 0 : 1;
      m_csr[3] = (kind == 2) ? instr : (kind >= 4) ? ifpc : '0;
    end
    e.is_read = 0;
    e.hit     = 1;
    e.rpc     = (kind == 3) ? m_csr[1] : m_csr[0];
    e.rdata   = m_csr[csr_idx(raddr)];
    e.req_cyc = cyc;
    e.extra   = (k > 0) ? k - 1 : 0;
    e.hold    = h;
    q.push_back(e);

    dec_valid   = (kind < 4);
    dec_ecall   = (kind == 0);
    dec_ebreak  = (kind == 1);
    dec_illegal = (kind == 2);
    dec_mret    = (kind == 3);
    dec_pc      = pc;
    dec_instr   = instr;
    if_fault      = (kind >= 4) || extra_fault;
    if_misaligned = (kind == 4) || ((kind < 4) && ($urandom_range(0, 1) == 1));
    if_pc         = ifpc;
    pipe_idle     = (k == 0);
    csr_wen = wen; csr_addr = waddr; csr_wdata = wdata;
    redirect_ready = 0;
    step();
    clear_req();
    csr_wen = busy_wr; csr_wdata = $urandom; csr_addr = raddr;
    for (int i = 1; i < k; i++) step();
    pipe_idle = 1;
    n = 0;
    while (!redirect_valid && n < 40) begin
      step();
      n++;
    end
    if (!redirect_valid) begin
      tests++; fails++;
      $display("FAIL redirect_timeout: redirect_valid still 0, expected 1 within 40 cycles");
      apply_reset();
    end else begin
      for (int i = 0; i < h; i++) step();
      redirect_ready = 1;
      step();
      redirect_ready = 0;
      csr_wen = 0;
    end
  endtask

  // Monitor
  exp_t            cur;
  bit              active = 0, pend_idle = 0, stray = 0;
  int              flush_cnt, rv_cnt;
  logic [XLEN-1:0] pc0;

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      chk("reset_busy", busy, 0);
      chk("reset_flush", flush, 0);
      chk("reset_redirect_valid", redirect_valid, 0);
      chk("reset_redirect_pc", redirect_pc, 0);
      active = 0; pend_idle = 0; stray = 0;
    end else begin
      if (pend_idle) begin
        chk("idle_after_accept", busy, 0);
        pend_idle = 0;
      end
      if (rd_chk) begin
        if (q.size() == 0 || !q[0].is_read) begin
          tests++; fails++;
          $display("FAIL read_order: no queued read expectation at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          chk("csr_rdata", csr_rdata, e.rdata);
          chk("csr_hit", csr_hit, e.hit);
        end
      end
      if (!active && busy) begin
        if (q.size() == 0 || q[0].is_read) begin
          if (!stray) begin
            tests++; fails++;
            $display("FAIL unexpected_busy: busy=1 with no trap issued, expected 0 (cycle %0d)", cyc);
          end
          stray = 1;
        end else begin
          cur = q.pop_front();
          active = 1; flush_cnt = 0; rv_cnt = 0;
          chk("busy_start_cycle", cyc, cur.req_cyc + 1);
        end
      end
      if (!busy) stray = 0;
      if (flush && !active) begin
        tests++; fails++;
        $display("FAIL stray_flush: flush=1 outside a sequence, expected 0 (cycle %0d)", cyc);
      end
      if (active) begin
        if (flush) begin
          flush_cnt++;
          chk("flush_cycle", cyc, cur.req_cyc + 2 + cur.extra);
        end
        if (!busy) begin
          tests++; fails++;
          $display("FAIL busy_dropped: busy=0 before redirect accepted, expected 1 (cycle %0d)", cyc);
          active = 0;
        end else if (redirect_valid) begin
          if (rv_cnt == 0) begin
            chk("redirect_latency", cyc, cur.req_cyc + 3 + cur.extra);
            pc0 = redirect_pc;
          end else begin
            chk("redirect_pc_stable", redirect_pc, pc0);
          end
          rv_cnt++;
          if (redirect_ready) begin
            chk("redirect_pc", redirect_pc, cur.rpc);
            chk("csr_at_redirect", csr_rdata, cur.rdata);
            chk("flush_count", flush_cnt, 1);
            chk("redirect_hold", rv_cnt, cur.hold + 1);
            active = 0;
            pend_idle = 1;
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b0;
    clear_req();
    dec_pc = '0; dec_instr = '0; if_pc = '0;
    pipe_idle = 1; redirect_ready = 0;
    csr_addr = '0; csr_wen = 0; csr_wdata = '0; rd_chk = 0;
    model_reset();
    step();
    step();
    rst = 1'b1;
    step();
    csr_read(12'h305); csr_read(12'h341); csr_read(12'h342); csr_read(12'h343);
    csr_read(12'h300);

    // ECALL with mtvec=0xC
    csr_write(12'h305, 32'hC);
    do_seq(0, 32'h4, 32'h0, 32'h0, 0, 0, 0, 12'h305, 32'h0, 0, 0, 12'h342);
    csr_read(12'h341); csr_read(12'h343);

    // mtvec alignment, then EBREAK
    csr_write(12'h305, 32'h27);
    csr_read(12'h305);
    do_seq(1, 32'h1C, 32'h0, 32'h0, 0, 0, 0, 12'h305, 32'h0, 0, 0, 12'h341);
    csr_read(12'h342); csr_read(12'h343);

    // Illegal instruction with pipe_idle low for 4 cycles
    do_seq(2, 32'h40, 32'hFFFF_FFFF, 32'h0, 4, 0, 0, 12'h305, 32'h0, 0, 0, 12'h343);
    csr_read(12'h342);

    // EBREAK and fetch fault together: decode wins
    do_seq(1, 32'h30, 32'h0, 32'h20, 0, 0, 0, 12'h305, 32'h0, 1, 0, 12'h343);
    csr_read(12'h342); csr_read(12'h341);

    // MRET with redirect_ready held low for 5 cycles
    csr_write(12'h341, 32'h1C);
    do_seq(3, 32'h88, 32'h0, 32'h0, 0, 5, 0, 12'h305, 32'h0, 0, 1, 12'h342);

    // CSR write in the trapping cycle is dropped
    do_seq(0, 32'h104, 32'h0, 32'h0, 1, 1, 1, 12'h305, 32'h100, 0, 0, 12'h305);
    csr_read(12'h305);

    // Decode flags without dec_valid never trap
    dec_ecall = 1; dec_mret = 1;
    step();
    clear_req();
    csr_read(12'h342);

    // Reset in the middle of DRAIN
    csr_write(12'h343, 32'hDEAD_BEE0);
    dec_valid = 1; dec_ecall = 1; dec_pc = 32'h200; pipe_idle = 0;
    begin
      exp_t e;
      e.is_read = 0; e.hit = 1; e.rdata = '0; e.rpc = '0;
      e.req_cyc = cyc; e.extra = 0; e.hold = 0;
      q.push_back(e);
    end
    step();
    clear_req();
    step();
    apply_reset();
    csr_read(12'h305); csr_read(12'h341); csr_read(12'h342); csr_read(12'h343);

    // Randomized traffic
    repeat (60) begin
      int kind;
      kind = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) csr_write(rand_addr(), $urandom);
      do_seq(kind, $urandom, $urandom, $urandom, $urandom_range(0, 4),
             $urandom_range(0, 3), ($urandom_range(0, 3) == 0), rand_hit_addr(),
             $urandom, (kind < 4) && ($urandom_range(0, 1) == 1),
             $urandom_range(0, 1), rand_hit_addr());
      csr_read(rand_addr());
    end

    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Machine-mode trap controller for the core. Accepts synchronous exception requests (ECALL, EBREAK, illegal instruction, fetch fault) and MRET. Owns the trap CSRs mtvec, mepc, mcause and mtval. Sequences every trap through four steps: drain the pipeline, commit the CSRs, flush, and redirect instruction fetch. It sits between decode/ifetch and the CSR unit.

## Interface
- XLEN, 32, register and PC width
- clk  in  1  core clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low
- dec_valid  in  1  decode holds a valid instruction this cycle
- dec_ecall / dec_ebreak / dec_illegal  in  1 each  decode exception flags; at most one is set
- dec_mret  in  1  decode holds MRET
- dec_pc  in  XLEN  PC of the decode instruction
- dec_instr  in  32  raw instruction bits
- if_fault  in  1  ifetch access fault or misalignment on the next instruction
- if_misaligned  in  1  qualifies if_fault: 1 = misaligned, 0 = access fault
- if_pc  in  XLEN  faulting fetch address
- pipe_idle  in  1  no older instruction is still in execute, LSU or writeback
- busy  out  1  a sequence is in progress; decode and ifetch stall
- flush  out  1  one-cycle pulse that invalidates fetch and decode
- redirect_valid  out  1  a new PC is offered to ifetch
- redirect_pc  out  XLEN  target PC
- redirect_ready  in  1  ifetch accepts the redirect
- csr_addr  in  12  CSR address of the CSR instruction in decode
- csr_wen  in  1  CSR write strobe
- csr_wdata  in  XLEN  CSR write data
- csr_hit  out  1  csr_addr is 0x305, 0x341, 0x342 or 0x343 (combinational)
- csr_rdata  out  XLEN  read data for csr_addr (combinational); 0 when there is no hit

## Operation
- States: IDLE, DRAIN, COMMIT, REDIRECT.
- In IDLE, a request is sampled on the clock edge and its request type, cause, pc and tval are latched. The request is one of:
  - dec_valid & (ecall | ebreak | illegal | mret)
  - if_fault
- Priority: decode exceptions and MRET beat if_fault, because the decode instruction is older. A fault on the next fetch is discarded, since the flush refetches it.
- Cause codes (mcause bit XLEN-1 is always 0):
  - ECALL 11, tval 0
  - EBREAK 3, tval 0
  - illegal instruction 2, tval = dec_instr zero-extended
  - fetch misaligned 0, tval = if_pc
  - fetch access fault 1, tval = if_pc
- DRAIN: wait until pipe_idle=1. If pipe_idle is already 1, DRAIN still lasts exactly one cycle.
- COMMIT, one cycle. flush=1.
  - Trap: mepc ← latched pc with bits[1:0] cleared; mcause ← cause; mtval ← tval.
  - MRET: the CSRs are unchanged.
- REDIRECT: redirect_valid=1.
  - Trap: redirect_pc = mtvec; MRET: redirect_pc = mepc.
  - redirect_pc is the value after COMMIT and is held stable until redirect_ready.
  - On the cycle redirect_valid & redirect_ready, the block returns to IDLE.
- busy = (state != IDLE).
- CSR writes take effect only in IDLE with csr_wen & csr_hit.
  - mtvec and mepc writes have bits[1:0] forced to 0; only direct mode is supported.
  - A CSR write and a trap request in the same IDLE cycle: the CSR write is dropped, because the trapping instruction must not retire.
  - CSR writes while busy are ignored. Decode is stalled by busy, so they do not occur legally.
- Reset values: state IDLE; mtvec, mepc, mcause and mtval all 0; busy, flush and redirect_valid 0; redirect_pc 0.
- Reset asserted mid-sequence returns the block to IDLE immediately. No flush or redirect is issued and the CSRs are cleared.

## Timing
- Request sampled at edge N → busy=1 from N+1.
- With pipe_idle=1: DRAIN during N+1, COMMIT (flush) during N+2, redirect_valid from N+3.
- CSR values read by csr_rdata are updated from the cycle after COMMIT, so they are visible when redirect_valid rises.
- Minimum trap-to-redirect latency is 3 cycles. Each cycle pipe_idle stays low in DRAIN adds one cycle.
- CSR write at edge N → visible on csr_rdata from N+1. The read of the same address in cycle N returns the old value.

## Test plan
- Write mtvec=0xC; ECALL at pc 0x4 → flush pulse; mcause=11, mepc=0x4, mtval=0; redirect_pc=0xC exactly 3 cycles after sampling.
- Write mtvec=0x24; EBREAK at pc 0x1C → mcause=3, mepc=0x1C, mtval=0, redirect_pc=0x24. A write of 0x27 to mtvec reads back as 0x24.
- Illegal instruction 0xFFFFFFFF at pc 0x40 with pipe_idle low for 4 cycles → DRAIN lasts 4 cycles; mcause=2, mtval=0xFFFFFFFF.
- EBREAK in decode and if_fault at pc 0x20 in the same cycle → only the EBREAK trap is taken; mcause=3, mtval=0.
- MRET with mepc=0x1C and redirect_ready held low for 5 cycles → redirect_valid and redirect_pc=0x1C stay stable for 5 cycles; mcause is unchanged; IDLE on the cycle of acceptance.
- Reset asserted during DRAIN → busy=0 and redirect_valid=0 immediately, with no flush pulse. After release all CSRs read 0.
